address_arbiter: RTL and testbench
==================================

ADDRESS_ARBITER -- requirements
Module: address_arbiter

Interface
- REQ-001 shall have parameter ARRAY_SIZE, default 9: number of address lanes per bus.
- REQ-002 shall have parameter ADDR_W, default 14: bits per lane address.
- REQ-003 shall have parameter NUM_SRC, default 3, legal 2..8: number of address sources.
- REQ-004 shall use derived widths BUS_W = ADDR_W*ARRAY_SIZE and SEL_W = max(1, clog2(NUM_SRC)).
- REQ-005 shall have one clock and an asynchronous, active-high reset; no other clock or reset shall exist.
- REQ-006 shall have these ports:
  - clk  input  1  rising-edge clock.
  - reset  input  1  asynchronous, active-high reset.
  - src_valid  input  NUM_SRC  per-source address beat valid.
  - src_addr  input  NUM_SRC*BUS_W  source i bus at bits [i*BUS_W +: BUS_W].
  - src_last  input  NUM_SRC  marks the final beat of the source's burst.
  - src_ready  output  NUM_SRC  per-source beat accepted.
  - mode  input  1  0 = manual select, 1 = round-robin.
  - sel  input  SEL_W  manual source index, used when mode=0.
  - out_valid  output  1  registered output beat valid.
  - out_addr  output  BUS_W  registered address bus.
  - out_src  output  SEL_W  index of the source that produced out_addr.
  - out_ready  input  1  downstream accepts the beat.
  - busy  output  1  a grant is locked.

Function
- REQ-007 shall implement FSM states IDLE and LOCKED, with a grant register of SEL_W bits and a last_grant register of SEL_W bits.
- REQ-008 In IDLE with mode=0, the block shall lock grant=sel and move to LOCKED next cycle when sel<NUM_SRC and src_valid[sel]=1; when sel>=NUM_SRC, no grant shall be issued.
- REQ-009 In IDLE with mode=1, the block shall grant the first source with src_valid=1, searching from last_grant+1 upward and wrapping modulo NUM_SRC, and shall move to LOCKED.
- REQ-010 If no eligible request exists in IDLE, the block shall stay in IDLE.
- REQ-011 mode and sel shall be sampled only in IDLE; changes while LOCKED shall be ignored.
- REQ-012 src_ready[i] shall be 1 only when state=LOCKED, i=grant, and (out_valid=0 or out_ready=1); all other src_ready bits shall be 0. src_ready shall be combinational.
- REQ-013 A transfer occurs when src_valid[grant] and src_ready[grant] are both 1. On a transfer, the next edge shall load out_addr with src_addr[grant], set out_src=grant and set out_valid=1.
- REQ-014 Latency from an accepted beat to out_valid shall be 1 cycle, and throughput shall be 1 beat/cycle while out_ready=1.
- REQ-015 When out_valid=1 and out_ready=0, out_addr, out_src and out_valid shall hold stable.
- REQ-016 When out_valid=1, out_ready=1 and no transfer occurs, out_valid shall clear; out_addr and out_src shall retain their last values.
- REQ-017 On a transfer with src_last[grant]=1, the block shall load last_grant with grant and return to IDLE next cycle. The next grant shall take a minimum of one IDLE arbitration cycle.
- REQ-018 src_valid[grant] deasserting mid-burst shall not release the grant; only a transfer carrying src_last shall release it.
- REQ-019 busy shall equal (state==LOCKED).
- REQ-020 The block shall perform no arithmetic on addresses; out_addr shall be a bit-exact copy of the source bus.

Reset
- REQ-021 Asserting reset at any time, including mid-burst, shall immediately force: state=IDLE, out_valid=0, out_addr=0, out_src=0, grant=0, last_grant=NUM_SRC-1, busy=0, src_ready=0.
- REQ-022 A beat pending in the output register at reset shall be discarded.
- REQ-023 After reset deasserts, the first round-robin grant shall go to source 0 when it is requesting.

Verification
- REQ-024 Manual select: mode=0, sel=1, src_valid=3'b010, src1 bus=0x155 per lane, src_last=1 -> busy=1 one cycle later; out_valid=1 with out_addr=0x155 per lane and out_src=1 one cycle after the transfer; then IDLE.
- REQ-025 Invalid select: mode=0, sel=3 (NUM_SRC=3), all src_valid=1 -> busy stays 0, src_ready=0, out_valid=0 for 10 cycles.
- REQ-026 Round-robin fairness: mode=1, all sources continuously valid, every beat has src_last=1 -> out_src sequence 0,1,2,0,1,2.
- REQ-027 Burst lock: src0 4-beat burst with addrs 0x001..0x004 and src_last on beat 4, src2 valid throughout -> out_addr 0x001..0x004 consecutive with out_src=0, then src2 granted.
- REQ-028 Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> out_addr stable, src_ready[grant]=0; releasing out_ready resumes one beat per cycle with no loss or duplication.
- REQ-029 Reset mid-burst: assert reset during beat 2 of a 4-beat burst -> out_valid=0, busy=0, out_addr=0 immediately; after release, round-robin grants source 0 first.

Source files
------------

// File: rtl/address_arbiter_if.sv
// Handshake bundle between the address sources, the arbiter and the downstream sink.
interface address_arbiter_if #(
  parameter int ARRAY_SIZE = 9,
  parameter int ADDR_W     = 14,
  parameter int NUM_SRC    = 3
);
  localparam int BUS_W = ADDR_W * ARRAY_SIZE;
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*BUS_W-1:0] src_addr;
  logic [NUM_SRC-1:0]       src_last;
  logic [NUM_SRC-1:0]       src_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic                     out_valid;
  logic [BUS_W-1:0]         out_addr;
  logic [SEL_W-1:0]         out_src;
  logic                     out_ready;
  logic                     busy;

  // Arbiter side.
  modport slave (
    input  src_valid, src_addr, src_last, mode, sel, out_ready,
    output src_ready, out_valid, out_addr, out_src, busy
  );

  // Source/sink side.
  modport master (
    output src_valid, src_addr, src_last, mode, sel, out_ready,
    input  src_ready, out_valid, out_addr, out_src, busy
  );
endinterface

// File: rtl/address_arbiter.sv
// Burst-locked address arbiter: manual or round-robin source selection feeding a
// single registered output stage that honours downstream backpressure.
module address_arbiter #(
  parameter int ARRAY_SIZE = 9,
  parameter int ADDR_W     = 14,
  parameter int NUM_SRC    = 3
) (
  input  logic             clk,
  input  logic             reset,
  address_arbiter_if.slave bus
);
  localparam int BUS_W = ADDR_W * ARRAY_SIZE;
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [SEL_W-1:0] LAST_SRC    = SEL_W'(NUM_SRC - 1);
  localparam logic [SEL_W:0]   NUM_SRC_EXT = (SEL_W + 1)'(NUM_SRC);

  logic [0:0]         state;
  logic [SEL_W-1:0]   grant;
  logic [SEL_W-1:0]   last_grant;
  logic               out_valid_q;
  logic [BUS_W-1:0]   out_addr_q;
  logic [SEL_W-1:0]   out_src_q;

  logic               sel_ok;
  logic               req_found;
  logic [SEL_W-1:0]   req_idx;
  logic [SEL_W-1:0]   rr_cand;

  logic [BUS_W-1:0]   grant_addr;
  logic               grant_valid;
  logic               grant_last;
  logic               out_free;
  logic               xfer;
  logic [NUM_SRC-1:0] src_ready;

  function automatic logic [SEL_W-1:0] next_src(input logic [SEL_W-1:0] idx);
    return (idx == LAST_SRC) ? '0 : idx + 1'b1;
  endfunction

  // Candidate grant for the IDLE state; only consumed there, so mode and sel
  // changes while a grant is locked have no effect.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    req_found = 1'b0;
    req_idx   = '0;
    rr_cand   = next_src(last_grant);
    sel_ok    = ({1'b0, bus.sel} < NUM_SRC_EXT);
    if (bus.mode) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!req_found && bus.src_valid[rr_cand]) begin
          req_found = 1'b1;
          req_idx   = rr_cand;
        end
        rr_cand = next_src(rr_cand);
      end
    end else if (sel_ok && bus.src_valid[bus.sel]) begin
      req_found = 1'b1;
      req_idx   = bus.sel;
    end
  end

  // Route the granted source and raise its ready while the output slot can take a beat.
  always_comb begin
    grant_addr  = '0;
    grant_valid = 1'b0;
    grant_last  = 1'b0;
    src_ready   = '0;
    out_free    = !out_valid_q || bus.out_ready;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_addr   = bus.src_addr[i*BUS_W +: BUS_W];
        grant_valid  = bus.src_valid[i];
        grant_last   = bus.src_last[i];
        src_ready[i] = (state == LOCKED) && out_free;
      end
    end
  end

  assign xfer = (state == LOCKED) && out_free && grant_valid;

  // Only a beat carrying src_last releases the grant; a gap in src_valid keeps it.
  // NOTE: asynchronous reset clears all state here; nothing is left to power-up values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_SRC;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (req_found) begin
            grant <= req_idx;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && grant_last) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: loads on a transfer, holds under backpressure, and drops valid
  // (keeping the last address/source) once the sink has taken it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_src_q   <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= grant_addr;
      out_src_q   <= grant;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.src_ready = src_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = (state == LOCKED);
endmodule

// File: tb/tb_address_arbiter.sv
// Self-checking bench for address_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the grant/output rules.
module tb_address_arbiter;
  localparam int ARRAY_SIZE = 9;
  localparam int ADDR_W     = 14;
  localparam int NUM_SRC    = 3;
  localparam int BUS_W      = ADDR_W * ARRAY_SIZE;
  localparam int SEL_W      = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int compared   = 0;
  int mismatched = 0;

  address_arbiter_if #(.ARRAY_SIZE(ARRAY_SIZE), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC)) bus ();

  address_arbiter #(.ARRAY_SIZE(ARRAY_SIZE), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [BUS_W-1:0] lanes(input logic [ADDR_W-1:0] v);
    return {ARRAY_SIZE{v}};
  endfunction

  task automatic set_addr(input int i, input logic [BUS_W-1:0] a);
    bus.src_addr[i*BUS_W +: BUS_W] = a;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    bus.src_valid = '0; bus.src_last = '0; bus.mode = 1'b0; bus.sel = '0; bus.out_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    compared++;
    if ({bus.busy, bus.out_valid, bus.src_ready, bus.out_src} !== 7'd0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got busy/valid/ready/src %b expected 0", {bus.busy, bus.out_valid, bus.src_ready, bus.out_src});
    end
    compared++;
    if (bus.out_addr !== '0) begin
      mismatched++; $display("FAIL reset_addr: got %h expected 0", bus.out_addr);
    end
    bus.src_valid = '1;
    bus.mode = 1'b1;
    @(posedge clk); #1;
    compared++;
    if ({bus.busy, bus.src_ready} !== 4'd0) begin
      mismatched++; $display("FAIL reset_held: got busy/ready %b expected 0", {bus.busy, bus.src_ready});
    end
    bus.src_valid = '0;
    bus.mode = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_manual();
    @(posedge clk); #1;
    bus.mode = 1'b0; bus.sel = 2'd1; bus.src_valid = 3'b010; bus.src_last = 3'b010;
    set_addr(1, lanes(14'h155));
    #1;
    compared++;
    if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL manual_idle: got busy %b expected 0", bus.busy); end
    @(posedge clk); #1;
    compared++;
    if ({bus.busy, bus.src_ready} !== 4'b1010) begin
      mismatched++; $display("FAIL manual_lock: got busy/ready %b expected 1010", {bus.busy, bus.src_ready});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.out_valid, bus.out_src, bus.busy} !== 4'b1010 || bus.out_addr !== lanes(14'h155)) begin
      mismatched++;
      $display("FAIL manual_out: got valid/src/busy %b addr %h expected 1010 addr %h", {bus.out_valid, bus.out_src, bus.busy}, bus.out_addr, lanes(14'h155));
    end
    bus.src_valid = '0; bus.src_last = '0;
    @(posedge clk); #1;
    compared++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== lanes(14'h155) || bus.out_src !== 2'd1) begin
      mismatched++;
      $display("FAIL manual_drain: got valid %b src %0d addr %h expected 0, 1, %h", bus.out_valid, bus.out_src, bus.out_addr, lanes(14'h155));
    end
  endtask

  task automatic test_invalid_sel();
    @(posedge clk); #1;
    bus.mode = 1'b0; bus.sel = 2'd3; bus.src_valid = 3'b111; bus.src_last = 3'b111;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      compared++;
      if ({bus.busy, bus.src_ready, bus.out_valid} !== 5'd0) begin
        mismatched++; $display("FAIL invalid_sel cycle %0d: got busy/ready/valid %b expected 0", c, {bus.busy, bus.src_ready, bus.out_valid});
      end
    end
    bus.src_valid = '0; bus.src_last = '0; bus.sel = '0;
  endtask

  task automatic test_round_robin();
    int got = 0;
    do_reset();
    for (int i = 0; i < NUM_SRC; i++) set_addr(i, lanes(ADDR_W'(14'h100 + i)));
    bus.mode = 1'b1; bus.src_last = '1; bus.src_valid = '1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        compared++;
        if (bus.out_src !== SEL_W'(got % NUM_SRC) || bus.out_addr !== lanes(ADDR_W'(14'h100 + got % NUM_SRC))) begin
          mismatched++;
          $display("FAIL rr_order beat %0d: got src %0d addr %h expected src %0d", got, bus.out_src, bus.out_addr, got % NUM_SRC);
        end
        got++;
        if (got == 6) bus.src_valid = '0;
      end
    end
    compared++;
    if (got != 6) begin mismatched++; $display("FAIL rr_timeout: got %0d beats expected 6", got); end
  endtask

  task automatic test_burst_lock();
    int b0 = 1;
    int got = 0;
    int first_cyc = -1;
    bit acc0, acc2;
    @(posedge clk); #1;
    bus.mode = 1'b1; bus.src_valid = 3'b101; bus.src_last = 3'b100;
    set_addr(0, lanes(ADDR_W'(b0))); set_addr(2, lanes(14'h2AA));
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (got == 0) first_cyc = cyc;
        compared++;
        if (got < 4) begin
          if (bus.out_src !== 2'd0 || bus.out_addr !== lanes(ADDR_W'(got + 1)) || cyc != first_cyc + got) begin
            mismatched++;
            $display("FAIL burst_beat %0d: got src %0d addr %h cyc %0d expected src 0 addr %h cyc %0d", got, bus.out_src, bus.out_addr, cyc, lanes(ADDR_W'(got + 1)), first_cyc + got);
          end
        end else if (bus.out_src !== 2'd2 || bus.out_addr !== lanes(14'h2AA)) begin
          mismatched++;
          $display("FAIL burst_next: got src %0d addr %h expected src 2 addr %h", bus.out_src, bus.out_addr, lanes(14'h2AA));
        end
        got++;
      end
      acc0 = bus.src_valid[0] && bus.src_ready[0];
      acc2 = bus.src_valid[2] && bus.src_ready[2];
      @(posedge clk); #1;
      if (acc0) begin
        if (b0 == 4) begin
          bus.src_valid[0] = 1'b0; bus.src_last[0] = 1'b0;
        end else begin
          b0++; set_addr(0, lanes(ADDR_W'(b0))); bus.src_last[0] = (b0 == 4);
        end
      end
      if (acc2) begin bus.src_valid[2] = 1'b0; bus.src_last[2] = 1'b0; end
    end
    compared++;
    if (got != 5) begin mismatched++; $display("FAIL burst_timeout: got %0d beats expected 5", got); end
  endtask

  task automatic test_backpressure();
    int b = 1;
    int got = 0;
    int stall_left = 0;
    bit started = 0;
    bit acc;
    @(posedge clk); #1;
    bus.mode = 1'b0; bus.sel = 2'd1; bus.src_valid = 3'b010; bus.src_last = 3'b000; bus.out_ready = 1'b1;
    set_addr(1, lanes(ADDR_W'(14'h10 + b)));
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        compared++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== lanes(14'h11) || bus.out_src !== 2'd1 || bus.src_ready !== 3'b000) begin
          mismatched++;
          $display("FAIL bp_hold: got valid %b src %0d ready %b addr %h expected 1, 1, 000, %h", bus.out_valid, bus.out_src, bus.src_ready, bus.out_addr, lanes(14'h11));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        compared++;
        if (bus.out_src !== 2'd1 || bus.out_addr !== lanes(ADDR_W'(14'h11 + got))) begin
          mismatched++;
          $display("FAIL bp_beat %0d: got src %0d addr %h expected src 1 addr %h", got, bus.out_src, bus.out_addr, lanes(ADDR_W'(14'h11 + got)));
        end
        got++;
      end
      acc = bus.src_valid[1] && bus.src_ready[1];
      @(posedge clk); #1;
      if (acc) begin
        if (b == 4) begin
          bus.src_valid[1] = 1'b0; bus.src_last[1] = 1'b0;
        end else begin
          b++; set_addr(1, lanes(ADDR_W'(14'h10 + b))); bus.src_last[1] = (b == 4);
        end
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) bus.out_ready = 1'b1;
      end else if (!started && bus.out_valid) begin
        started = 1; stall_left = 5; bus.out_ready = 1'b0;
      end
    end
    compared++;
    if (got != 4) begin mismatched++; $display("FAIL bp_timeout: got %0d beats expected 4", got); end
    @(posedge clk); #1;
    compared++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      mismatched++; $display("FAIL bp_extra: got valid/busy %b expected 00", {bus.out_valid, bus.busy});
    end
  endtask

  task automatic test_reset_mid_burst();
    int b = 1;
    int got = 0;
    bit acc;
    @(posedge clk); #1;
    bus.mode = 1'b1; bus.src_valid = 3'b010; bus.src_last = 3'b000;
    set_addr(1, lanes(ADDR_W'(14'h20 + b)));
    for (int cyc = 0; cyc < 20 && b < 2; cyc++) begin
      @(negedge clk);
      acc = bus.src_valid[1] && bus.src_ready[1];
      @(posedge clk); #1;
      if (acc) begin b++; set_addr(1, lanes(ADDR_W'(14'h20 + b))); end
    end
    compared++;
    if (b != 2) begin mismatched++; $display("FAIL rst_mid_setup: got beat %0d expected 2", b); end
    #2 reset = 1'b1;
    #1;
    compared++;
    if ({bus.out_valid, bus.busy, bus.src_ready, bus.out_src} !== 7'd0 || bus.out_addr !== '0) begin
      mismatched++;
      $display("FAIL rst_mid_clear: got valid/busy/ready/src %b addr %h expected 0", {bus.out_valid, bus.busy, bus.src_ready, bus.out_src}, bus.out_addr);
    end
    bus.src_valid = 3'b111; bus.src_last = 3'b111;
    for (int i = 0; i < NUM_SRC; i++) set_addr(i, lanes(ADDR_W'(14'h30 + i)));
    @(posedge clk); #1;
    reset = 1'b0;
    for (int cyc = 0; cyc < 10 && got < 1; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        compared++;
        if (bus.out_src !== 2'd0 || bus.out_addr !== lanes(14'h30)) begin
          mismatched++;
          $display("FAIL rst_mid_first: got src %0d addr %h expected src 0 addr %h", bus.out_src, bus.out_addr, lanes(14'h30));
        end
        got++;
        bus.src_valid = '0;
      end
    end
    compared++;
    if (got != 1) begin mismatched++; $display("FAIL rst_mid_timeout: got %0d beats expected 1", got); end
  endtask

  // Model: owner = source holding the grant (-1 when none), last = most recent
  // source to finish a burst, plus the contents of the one-deep output slot.
  task automatic test_random();
    int m_owner = -1;
    int m_last  = NUM_SRC - 1;
    bit m_ov    = 0;
    logic [BUS_W-1:0] m_oa = '0;
    int m_os    = 0;
    logic [NUM_SRC-1:0] exp_ready;
    bit xfer;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.src_valid = NUM_SRC'($urandom);
      for (int i = 0; i < NUM_SRC; i++) begin
        bus.src_last[i] = ($urandom_range(0, 2) == 0);
        for (int l = 0; l < ARRAY_SIZE; l++) bus.src_addr[i*BUS_W + l*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      bus.sel = SEL_W'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_ready = '0;
      if (m_owner >= 0 && (!m_ov || bus.out_ready)) exp_ready[m_owner] = 1'b1;
      compared++;
      if ({bus.busy, bus.out_valid, bus.src_ready, bus.out_src} !== {m_owner >= 0, m_ov, exp_ready, SEL_W'(m_os)}) begin
        mismatched++;
        $display("FAIL rand_ctrl cyc %0d: got busy/valid/ready/src %b expected %b", cyc, {bus.busy, bus.out_valid, bus.src_ready, bus.out_src}, {m_owner >= 0, m_ov, exp_ready, SEL_W'(m_os)});
      end
      compared++;
      if (bus.out_addr !== m_oa) begin
        mismatched++; $display("FAIL rand_addr cyc %0d: got %h expected %h", cyc, bus.out_addr, m_oa);
      end
      xfer = 0;
      if (m_owner >= 0) xfer = exp_ready[m_owner] && bus.src_valid[m_owner];
      if (xfer) begin
        m_ov = 1; m_oa = bus.src_addr[m_owner*BUS_W +: BUS_W]; m_os = m_owner;
      end else if (bus.out_ready) begin
        m_ov = 0;
      end
      if (m_owner < 0) begin
        if (bus.mode) begin
          for (int k = 1; k <= NUM_SRC; k++) begin
            if (m_owner < 0 && bus.src_valid[(m_last + k) % NUM_SRC]) m_owner = (m_last + k) % NUM_SRC;
          end
        end else if (int'(bus.sel) < NUM_SRC && bus.src_valid[bus.sel]) begin
          m_owner = int'(bus.sel);
        end
      end else if (xfer && bus.src_last[m_owner]) begin
        m_last = m_owner; m_owner = -1;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.src_valid = '0; bus.src_addr = '0; bus.src_last = '0;
    bus.mode = 1'b0; bus.sel = '0; bus.out_ready = 1'b1;
    test_reset();
    test_manual();
    test_invalid_sel();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
